// File: rtl/apb_pkg.sv
// Shared APB master definitions: the four-phase transfer state machine encoding.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/apb3_req_master.sv
// Valid/ready request to APB3 bridge; accept->response is 3 cycles plus completer wait states.
// One transfer in flight: REQ_READY only in IDLE, response held until RSP_READY.
module apb3_req_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int             CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LIM = CW'(TIMEOUT_CYCLES);
  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);

  apb_mst_state_t        r_state;
  apb_mst_state_t        w_state_nxt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_timeout;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_expire;

  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // PREADY is tested first so a completion always wins over an expiring count.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (REQ_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (TO_EN && (w_cnt_inc == TO_LIM)) begin
          w_expire    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_write <= REQ_WRITE;
        r_addr  <= REQ_ADDR;
        r_wdata <= REQ_WDATA;
        r_cnt   <= '0;
      end else if (r_state == ACCESS && !PREADY) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_done) begin
        r_rdata   <= (!r_write && !PSLVERR) ? PRDATA : '0;
        r_err     <= PSLVERR;
        r_timeout <= 1'b0;
      end else if (w_expire) begin
        r_rdata   <= '0;
        r_err     <= 1'b1;
        r_timeout <= 1'b1;
      end
    end
  end

  // Gating with RST keeps REQ_READY low for the whole reset pulse.
  assign REQ_READY   = (r_state == IDLE) && !RST;
  assign PSEL        = (r_state == SETUP) || (r_state == ACCESS);
  assign PENABLE     = (r_state == ACCESS);
  assign PWRITE      = r_write;
  assign PADDR       = r_addr;
  assign PWDATA      = r_wdata;
  assign RSP_VALID   = (r_state == RESP);
  assign RSP_RDATA   = r_rdata;
  assign RSP_ERR     = r_err;
  assign RSP_TIMEOUT = r_timeout;

endmodule

// File: doc/apb3_req_master.md
APB3_REQ_MASTER -- requirements
Module: apb3_req_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB/request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB/request data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase wait cycles; 0 disables timeout.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port REQ_VALID  input  1  request present.
REQ-007 SHALL have port REQ_READY  output  1  request accepted when high with REQ_VALID.
REQ-008 SHALL have port REQ_WRITE  input  1  1=write, 0=read.
REQ-009 SHALL have port REQ_ADDR  input  ADDR_WIDTH  transfer address.
REQ-010 SHALL have port REQ_WDATA  input  DATA_WIDTH  write data.
REQ-011 SHALL have port RSP_VALID  output  1  response present.
REQ-012 SHALL have port RSP_READY  input  1  response consumed when high with RSP_VALID.
REQ-013 SHALL have port RSP_RDATA  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-014 SHALL have port RSP_ERR  output  1  PSLVERR seen or timeout.
REQ-015 SHALL have port RSP_TIMEOUT  output  1  transfer aborted by timeout.
REQ-016 SHALL have ports PSEL, PENABLE, PWRITE  output  1 each  APB3 control.
REQ-017 SHALL have ports PADDR  output  ADDR_WIDTH and PWDATA  output  DATA_WIDTH  APB3 address/write data.
REQ-018 SHALL have ports PRDATA  input  DATA_WIDTH, PREADY  input  1, PSLVERR  input  1  APB3 completer response.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding max.
REQ-020 SHALL drive REQ_READY=1 only in IDLE; on REQ_VALID&&REQ_READY latch write/addr/wdata, go SETUP.
REQ-021 SHALL in SETUP drive PSEL=1, PENABLE=0 for exactly one cycle, then go ACCESS unconditionally.
REQ-022 SHALL in ACCESS drive PSEL=1, PENABLE=1 until PREADY=1 or timeout.
REQ-023 SHALL hold PADDR, PWRITE, PWDATA stable from SETUP entry to ACCESS exit; PADDR/PWDATA hold last value when idle.
REQ-024 SHALL on PREADY=1 in ACCESS capture PRDATA (reads only), RSP_ERR=PSLVERR, RSP_TIMEOUT=0, go RESP.
REQ-025 SHALL count ACCESS cycles with PREADY=0 in a counter cleared on SETUP entry; on count reaching TIMEOUT_CYCLES (nonzero) set RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0, go RESP.
REQ-026 SHALL drive PSEL=0, PENABLE=0 in IDLE and RESP.
REQ-027 SHALL in RESP assert RSP_VALID with RSP_* stable until RSP_READY=1, then go IDLE next cycle.
REQ-028 SHALL give minimum latency: accept cycle N, SETUP N+1, ACCESS N+2 (PREADY=1), RSP_VALID N+3; next accept no earlier than cycle after RSP handshake.
REQ-029 SHALL ignore PREADY/PSLVERR/PRDATA outside ACCESS.
REQ-030 SHALL give PREADY priority over timeout when both occur in the same cycle.

Reset
REQ-031 SHALL on RST=1 immediately force IDLE, all outputs 0 (REQ_READY rises first cycle after release), counter 0.
REQ-032 SHALL abort any in-flight transfer on reset mid-operation without producing a response.

Structure
REQ-033 SHALL place state enum apb_mst_state_t in shared package apb_pkg.
REQ-034 SHALL be a single module; no sub-module required.

Verification
REQ-035 Write 0x10<-0xDEADBEEF, PREADY=1 first ACCESS -> PSEL 2 cycles, PENABLE 1 cycle, RSP_VALID at N+3, RSP_ERR=0, RSP_RDATA=0.
REQ-036 Read 0x20, PREADY after 3 wait cycles, PRDATA=0x12345678 -> RSP_RDATA=0x12345678, PADDR stable all 4 ACCESS cycles.
REQ-037 Read with PSLVERR=1, PREADY=1 -> RSP_ERR=1, RSP_TIMEOUT=0.
REQ-038 PREADY held 0, TIMEOUT_CYCLES=16 -> PSEL drops after 16 ACCESS cycles, RSP_ERR=1, RSP_TIMEOUT=1.
REQ-039 RSP_READY=0 for 5 cycles, then RST=1 during next ACCESS -> response held stable 5 cycles; reset drops PSEL same cycle, no RSP_VALID after.
